wb_bus_guard: RTL and testbench

- Wishbone address decoder and watchdog between the arbitrated master port and four 16-bit slaves.
- Decodes each request to a slave strobe and relays that slave's ack and read data back to the master.
- Terminates any cycle that hits no slave (memory violation) or gets no ack within TIMEOUT cycles (timeout).
- Emits the one-cycle bm_* event record consumed by the bus status/count registers.

---
 rtl/wb_bus_guard_if.sv | 37 +++
 rtl/wb_bus_guard.sv | 206 ++++++++++++++++++++
 tb/tb_wb_bus_guard.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bus_guard_if.sv
// Wishbone master/slave signal bundle seen by the bus guard.
// The guard connects on the slave modport; the upstream side uses master.
interface wb_bus_guard_if;
  logic        m_cyc_i;
  logic        m_stb_i;
  logic        m_we_i;
  logic [15:0] m_adr_i;
  logic [15:0] m_dat_i;
  logic [1:0]  m_id_i;
  logic [15:0] m_dat_o;
  logic        m_ack_o;
  logic        s_cyc_o;
  logic [3:0]  s_stb_o;
  logic        s_we_o;
  logic [15:0] s_adr_o;
  logic [15:0] s_dat_o;
  logic [63:0] s_dat_i;
  logic [3:0]  s_ack_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i,
    input  m_adr_i, m_dat_i, m_id_i,
    output m_dat_o, m_ack_o,
    output s_cyc_o, s_stb_o, s_we_o,
    output s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i,
    output m_adr_i, m_dat_i, m_id_i,
    input  m_dat_o, m_ack_o,
    input  s_cyc_o, s_stb_o, s_we_o,
    input  s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_bus_guard.sv
// Wishbone address decoder and watchdog for four 16-bit slaves.
// Unmapped or unanswered cycles are acked with 16'hdead plus an event.
module wb_bus_guard #(
  parameter int          TIMEOUT   = 1024,
  parameter logic [15:0] SLV0_BASE = 16'h0000,
  parameter logic [15:0] SLV0_MASK = 16'hC000,
  parameter logic [15:0] SLV1_BASE = 16'h4000,
  parameter logic [15:0] SLV1_MASK = 16'hC000,
  parameter logic [15:0] SLV2_BASE = 16'h8000,
  parameter logic [15:0] SLV2_MASK = 16'hC000,
  parameter logic [15:0] SLV3_BASE = 16'hC000,
  parameter logic [15:0] SLV3_MASK = 16'hC000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  wb_bus_guard_if.slave bus,
  output logic        bm_memv,
  output logic        bm_timeout,
  output logic [1:0]  bm_wbm_id,
  output logic [15:0] bm_addr,
  output logic        bm_we
);

  localparam logic [15:0] DEAD    = 16'hdead;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] adr_q, adr_d;
  logic        we_q, we_d;
  logic [15:0] wdat_q, wdat_d;
  logic [1:0]  id_q, id_d;
  logic        cyc_q, cyc_d;
  logic [3:0]  stb_q, stb_d;
  logic        ack_q, ack_d;
  logic [15:0] rdat_q, rdat_d;
  logic        memv_q, memv_d;
  logic        to_q, to_d;
  logic [15:0] bm_addr_q, bm_addr_d;
  logic        bm_we_q, bm_we_d;
  logic [1:0]  bm_id_q, bm_id_d;

  logic [3:0]  hit;
  logic [15:0] slv_rdat;
  logic        slv_ack;
  logic        req;

  assign req     = bus.m_cyc_i & bus.m_stb_i & ~ack_q;
  assign slv_ack = |(bus.s_ack_i & stb_q);

  // Address decode, lowest slave index wins on overlap.
  always_comb begin
    hit = 4'b0000;
    priority case (1'b1)
      ((bus.m_adr_i & SLV0_MASK) == SLV0_BASE): hit = 4'b0001;
      ((bus.m_adr_i & SLV1_MASK) == SLV1_BASE): hit = 4'b0010;
      ((bus.m_adr_i & SLV2_MASK) == SLV2_BASE): hit = 4'b0100;
      ((bus.m_adr_i & SLV3_MASK) == SLV3_BASE): hit = 4'b1000;
      default:                                  hit = 4'b0000;
    endcase
  end

  // Read data slice of the currently strobed slave.
  always_comb begin
    slv_rdat = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      if (stb_q[i]) begin
        slv_rdat = bus.s_dat_i[16*i +: 16];
      end
    end
  end

  // Next state, slave strobes, master response and event record.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    we_d      = we_q;
    wdat_d    = wdat_q;
    id_d      = id_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    ack_d     = 1'b0;
    rdat_d    = rdat_q;
    memv_d    = 1'b0;
    to_d      = 1'b0;
    bm_addr_d = bm_addr_q;
    bm_we_d   = bm_we_q;
    bm_id_d   = bm_id_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          adr_d  = bus.m_adr_i;
          we_d   = bus.m_we_i;
          wdat_d = bus.m_dat_i;
          id_d   = bus.m_id_i;
          if (|hit) begin
            state_d = ACTIVE;
            cnt_d   = 16'h0000;
            cyc_d   = 1'b1;
            stb_d   = hit;
          end else begin
            state_d = RESP;
          end
        end
      end
      ACTIVE: begin
        if (!bus.m_cyc_i) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          stb_d   = 4'b0000;
        end else if (slv_ack) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          stb_d   = 4'b0000;
          ack_d   = 1'b1;
          rdat_d  = slv_rdat;
        end else if (cnt_q == TO_LAST) begin
          state_d   = IDLE;
          cyc_d     = 1'b0;
          stb_d     = 4'b0000;
          ack_d     = 1'b1;
          rdat_d    = DEAD;
          to_d      = 1'b1;
          bm_addr_d = adr_q;
          bm_we_d   = we_q;
          bm_id_d   = id_q;
        end else begin
          cnt_d = cnt_q + 16'h0001;
        end
      end
      RESP: begin
        state_d   = IDLE;
        ack_d     = 1'b1;
        rdat_d    = DEAD;
        memv_d    = 1'b1;
        bm_addr_d = adr_q;
        bm_we_d   = we_q;
        bm_id_d   = id_q;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 4'b0000;
      end
    endcase
  end

  // State and output registers; reset drops the strobes at once.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      wdat_q    <= '0;
      id_q      <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= '0;
      ack_q     <= 1'b0;
      rdat_q    <= '0;
      memv_q    <= 1'b0;
      to_q      <= 1'b0;
      bm_addr_q <= '0;
      bm_we_q   <= 1'b0;
      bm_id_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      wdat_q    <= wdat_d;
      id_q      <= id_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      ack_q     <= ack_d;
      rdat_q    <= rdat_d;
      memv_q    <= memv_d;
      to_q      <= to_d;
      bm_addr_q <= bm_addr_d;
      bm_we_q   <= bm_we_d;
      bm_id_q   <= bm_id_d;
    end
  end

  assign bus.m_dat_o = rdat_q;
  assign bus.m_ack_o = ack_q;
  assign bus.s_cyc_o = cyc_q;
  assign bus.s_stb_o = stb_q;
  assign bus.s_we_o  = we_q;
  assign bus.s_adr_o = adr_q;
  assign bus.s_dat_o = wdat_q;

  assign bm_memv    = memv_q;
  assign bm_timeout = to_q;
  assign bm_wbm_id  = bm_id_q;
  assign bm_addr    = bm_addr_q;
  assign bm_we      = bm_we_q;

endmodule

// File: tb/tb_wb_bus_guard.sv
// Scoreboard bench for wb_bus_guard: stimulus queues expected acks,
// a negedge monitor pops and compares each master ack.
module tb_wb_bus_guard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_bus_guard_if bus();

  logic        bm_memv;
  logic        bm_timeout;
  logic [1:0]  bm_wbm_id;
  logic [15:0] bm_addr;
  logic        bm_we;

  wb_bus_guard #(
    .TIMEOUT   (8),
    .SLV3_BASE (16'hC000),
    .SLV3_MASK (16'h0000)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .bus        (bus),
    .bm_memv    (bm_memv),
    .bm_timeout (bm_timeout),
    .bm_wbm_id  (bm_wbm_id),
    .bm_addr    (bm_addr),
    .bm_we      (bm_we)
  );

  typedef struct {
    logic [15:0] dat;
    logic        memv;
    logic        to;
    logic [15:0] addr;
    logic        we;
    logic [1:0]  id;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t pe;
  exp_t me;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [3:0]  exp_sel = 4'b0000;
  logic [15:0] exp_adr = 16'h0000;
  logic        exp_we = 1'b0;
  logic [15:0] exp_wdat = 16'h0000;
  logic [15:0] exp_bm_addr = 16'h0000;
  logic        exp_bm_we = 1'b0;
  logic [1:0]  exp_bm_id = 2'b00;

  int          lat[4] = '{1000, 1000, 1000, 1000};
  logic [15:0] rd[4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  int          scnt[4] = '{0, 0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Slave model: slave n acks on the lat[n]-th cycle of its strobe.
  initial begin
    bus.s_ack_i = 4'b0000;
    bus.s_dat_i = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (bus.s_cyc_o && bus.s_stb_o[i]) scnt[i] = scnt[i] + 1;
        else scnt[i] = 0;
        bus.s_ack_i[i] = (scnt[i] == lat[i]);
        bus.s_dat_i[16*i +: 16] = rd[i];
      end
    end
  end

  // Monitor: every master ack must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.m_ack_o) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ack: got ack with empty queue at cycle %0d", cyc);
          end else begin
            me = sbq.pop_front();
            check("ack_cycle", 64'(cyc), 64'(me.due));
            check("m_dat_o", 64'(bus.m_dat_o), 64'(me.dat));
            check("bm_memv", 64'(bm_memv), 64'(me.memv));
            check("bm_timeout", 64'(bm_timeout), 64'(me.to));
            check("stb_at_ack", 64'(bus.s_stb_o), 64'(0));
            if (me.memv || me.to) begin
              exp_bm_addr = me.addr;
              exp_bm_we   = me.we;
              exp_bm_id   = me.id;
            end
            check("bm_addr", 64'(bm_addr), 64'(exp_bm_addr));
            check("bm_we", 64'(bm_we), 64'(exp_bm_we));
            check("bm_wbm_id", 64'(bm_wbm_id), 64'(exp_bm_id));
          end
        end else if (bm_memv || bm_timeout) begin
          tests++;
          fails++;
          $display("FAIL event_no_ack: memv %b timeout %b without ack",
                   bm_memv, bm_timeout);
        end
        if (bus.s_stb_o != 4'b0000) begin
          check("s_stb_o", 64'(bus.s_stb_o), 64'(exp_sel));
          check("s_cyc_o", 64'(bus.s_cyc_o), 64'(1));
          check("s_adr_o", 64'(bus.s_adr_o), 64'(exp_adr));
          check("s_we_o", 64'(bus.s_we_o), 64'(exp_we));
          check("s_dat_o", 64'(bus.s_dat_o), 64'(exp_wdat));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One transfer; sel=0 means unmapped, l>8 means the slave stays silent.
  task automatic xfer(input logic [15:0] adr, input logic we,
                      input logic [15:0] wd, input logic [1:0] id,
                      input logic [3:0] sel, input int l,
                      input logic [15:0] rdat, input int skip,
                      input bit hold);
    int n;
    exp_sel  = sel;
    exp_adr  = adr;
    exp_we   = we;
    exp_wdat = wd;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        lat[i] = l;
        rd[i]  = rdat;
      end
    end
    pe.addr = adr;
    pe.we   = we;
    pe.id   = id;
    pe.memv = 1'b0;
    pe.to   = 1'b0;
    if (sel == 4'b0000) begin
      pe.memv = 1'b1;
      pe.dat  = 16'hdead;
      pe.due  = cyc + skip + 2;
    end else if (l > 8) begin
      pe.to  = 1'b1;
      pe.dat = 16'hdead;
      pe.due = cyc + skip + 9;
    end else begin
      pe.dat = rdat;
      pe.due = cyc + skip + 1 + l;
    end
    sbq.push_back(pe);
    bus.m_cyc_i = 1'b1;
    bus.m_stb_i = 1'b1;
    bus.m_we_i  = we;
    bus.m_adr_i = adr;
    bus.m_dat_i = wd;
    bus.m_id_i  = id;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.m_ack_o) break;
    end
    if (n == 40) begin
      tests++;
      fails++;
      $display("FAIL ack_wait: no ack for adr %h within 40 cycles", adr);
    end
    if (!hold) begin
      bus.m_cyc_i = 1'b0;
      bus.m_stb_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    bus.m_we_i  = 1'b0;
    bus.m_adr_i = 16'h0000;
    bus.m_dat_i = 16'h0000;
    bus.m_id_i  = 2'b00;
    idle(2);
    check("rst_m_ack", 64'(bus.m_ack_o), 64'(0));
    check("rst_m_dat", 64'(bus.m_dat_o), 64'(0));
    check("rst_s_cyc", 64'(bus.s_cyc_o), 64'(0));
    check("rst_s_stb", 64'(bus.s_stb_o), 64'(0));
    check("rst_bm", 64'({bm_memv, bm_timeout, bm_wbm_id, bm_addr, bm_we}),
          64'(0));
    rst_n = 1'b1;
    idle(2);

    xfer(16'h4010, 1'b0, 16'h0000, 2'd1, 4'b0010, 3, 16'h1234, 0, 1'b0);
    idle(2);
    xfer(16'hC000, 1'b1, 16'h5555, 2'd2, 4'b0000, 0, 16'h0000, 0, 1'b0);
    idle(2);
    xfer(16'h0020, 1'b0, 16'h0000, 2'd3, 4'b0001, 1000, 16'h0000, 0, 1'b0);
    idle(2);
    xfer(16'h0040, 1'b0, 16'h0000, 2'd1, 4'b0001, 8, 16'hBEEF, 0, 1'b0);
    idle(2);
    xfer(16'h8002, 1'b1, 16'hA5A5, 2'd0, 4'b0100, 1, 16'h0777, 0, 1'b0);
    idle(2);

    exp_sel  = 4'b0001;
    exp_adr  = 16'h0100;
    exp_we   = 1'b0;
    exp_wdat = 16'h0000;
    lat[0]   = 1000;
    bus.m_cyc_i = 1'b1;
    bus.m_stb_i = 1'b1;
    bus.m_we_i  = 1'b0;
    bus.m_adr_i = 16'h0100;
    bus.m_dat_i = 16'h0000;
    bus.m_id_i  = 2'd1;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.s_stb_o != 4'b0000) break;
    end
    check("abort_stb_up", 64'(bus.s_stb_o), 64'(4'b0001));
    idle(2);
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    @(negedge clk);
    check("abort_stb_drop", 64'(bus.s_stb_o), 64'(0));
    check("abort_cyc_drop", 64'(bus.s_cyc_o), 64'(0));
    idle(12);
    check("m_dat_hold", 64'(bus.m_dat_o), 64'(16'h0777));

    xfer(16'h4000, 1'b0, 16'h0000, 2'd2, 4'b0010, 2, 16'h0042, 0, 1'b0);
    idle(2);

    xfer(16'h4100, 1'b0, 16'h0000, 2'd0, 4'b0010, 4, 16'h1111, 0, 1'b1);
    xfer(16'h0200, 1'b0, 16'h0000, 2'd0, 4'b0001, 8, 16'h2222, 1, 1'b0);
    idle(3);

    exp_sel  = 4'b0100;
    exp_adr  = 16'h8000;
    exp_we   = 1'b0;
    exp_wdat = 16'h0000;
    lat[2]   = 1000;
    bus.m_cyc_i = 1'b1;
    bus.m_stb_i = 1'b1;
    bus.m_adr_i = 16'h8000;
    bus.m_id_i  = 2'd3;
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_stb", 64'(bus.s_stb_o), 64'(0));
    check("rst_mid_cyc", 64'(bus.s_cyc_o), 64'(0));
    check("rst_mid_ack", 64'(bus.m_ack_o), 64'(0));
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);
    check("rst_mid_bm", 64'({bm_memv, bm_timeout, bm_addr}), 64'(0));
    check("queue_empty", 64'(sbq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
